multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the shared multicycle MIPS datapath (PC, IR, register file, ALU, unified memory) over several clocks per instruction.
- Supports the same 5-bit opcode set and ALU op encodings as the single-cycle decoder: AND 0x0, OR 0x1, ADD 0x2, SUB 0x6, SLT 0x7, LW 0x8, SW 0xA, BNE 0xE.
- Owns the memory request/ready handshake, including a wait-state timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive wait cycles with mem_req high and mem_ready low before a bus error is declared (must be ≥1).
- CNT_W, 5, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  allows fetch; when low, the block idles in FETCH
- opcode  input  5  IR[opcode field]; valid from the DECODE cycle onward
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  write strobe, valid with mem_req
- i_or_d  output  1  address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  load IR
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero==0 (BNE)
- pc_source  output  1  0 = ALU result, 1 = ALUOut (branch target)
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 1, 10 = sign-extended imm, 11 = PC-relative offset
- alu_op  output  3  000 AND, 001 OR, 011 ADD, 100 SUB, 101 SLT
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write enable
- state  output  4  current state, for debug
- illegal  output  1  sticky flag: undefined opcode seen
- bus_error  output  1  sticky flag: memory timeout

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, MEM_ADDR=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, BRANCH=8. Unused codes go to FETCH.
- Reset (async, rst_n=0):
  - state=FETCH; op_q=0; wait_cnt=0; illegal=0; bus_error=0.
  - Outputs follow FETCH decode with run sampled.
- Output defaults are 0 in every state unless listed below.
- FETCH:
  - alu_src_a=0, alu_src_b=01, alu_op=011, i_or_d=0.
  - mem_req=run.
  - ir_write = pc_write = run & mem_ready (Mealy).
  - Transition to DECODE on run & mem_ready; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=011.
  - op_q <= opcode.
  - R-type (0, 1, 2, 6, 7) -> EXEC_R.
  - LW/SW -> MEM_ADDR.
  - BNE -> BRANCH.
  - Any other opcode: illegal <= 1, next state FETCH (treated as a NOP).
- EXEC_R:
  - alu_src_a=1, alu_src_b=00.
  - alu_op from op_q: 0->000, 1->001, 2->011, 6->100, 7->101.
  - Next state WB_R.
- WB_R: reg_dst=1, mem_to_reg=0, reg_write=1; alu_op held as in EXEC_R. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=011. Next state MEM_RD if op_q=0x8, else MEM_WR.
- MEM_RD: i_or_d=1, mem_req=1. Next state WB_MEM on mem_ready.
- WB_MEM: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEM_WR: i_or_d=1, mem_req=1, mem_we=1. Next state FETCH on mem_ready.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_source=1, pc_write_cond=1. Next state FETCH.
- Handshake rules:
  - mem_req, mem_we and i_or_d are held stable until the cycle mem_ready=1; the request completes in that cycle.
  - mem_ready is ignored when mem_req=0.
- Timeout:
  - wait_cnt clears on each state change and whenever mem_req=0.
  - It increments each cycle mem_req=1 & mem_ready=0.
  - If wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: bus_error <= 1, state -> FETCH, no IR/PC/register write.
  - mem_ready=1 in the same cycle wins over the timeout.
  - After a FETCH timeout the same PC is refetched.
- Flags: illegal and bus_error clear only on reset.
- Reset mid-access: mem_req drops asynchronously; no write strobes are issued.
- Latency: R-type 4 cycles; LW 5; SW 4; BNE 3 — each plus memory wait cycles.

Test Plan:
- ADD, opcode=0x2, mem_ready=1 always, run=1 -> state sequence 0,1,2,3,0; reg_write=1 and reg_dst=1 in state 3 only; alu_op=011 in states 2 and 3.
- LW, opcode=0x8, mem_ready low for 2 cycles in MEM_RD -> mem_req=1 and i_or_d=1 for 3 cycles; WB_MEM has mem_to_reg=1 and reg_write=1; total 7 cycles.
- SW 0xA then BNE 0xE -> mem_we=1 only in MEM_WR; BRANCH cycle has pc_write_cond=1, alu_op=100, pc_source=1; reg_write never set.
- Opcode 0x1F -> illegal=1 from the cycle after DECODE and remains set; no write enables; returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 wait cycles; state stays/returns to 0; ir_write never pulses. Repeat with mem_ready=1 on the 4th cycle -> no error.
- rst_n pulled low during MEM_WR -> mem_we/mem_req drop immediately; after release, state=0 with flags 0; run=0 keeps mem_req=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Memory request/ready handshake between the multicycle control FSM and
// the unified instruction/data memory.
//   mem_req   : controller -> memory, access request
//   mem_we    : controller -> memory, write strobe (valid with mem_req)
//   i_or_d    : controller -> datapath address mux, 0 = PC, 1 = ALUOut
//   mem_ready : memory -> controller, current request completes this cycle
// ---------------------------------------------------------------------------
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Control FSM for the shared multicycle MIPS datapath. Sequences each
// instruction over several clocks (R-type 4, LW 5, SW 4, BNE 3, plus memory
// wait cycles), owns the memory handshake and declares a sticky bus error
// when a request waits too long.
//
// Parameters
//   MEM_TIMEOUT : wait cycles (mem_req=1, mem_ready=0) tolerated before a
//                 bus error; must be >= 1
//   CNT_W       : width of the wait counter; must hold MEM_TIMEOUT
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   run             : allows instruction fetch; low keeps the FSM in FETCH
//   opcode[4:0]     : IR opcode field, valid from DECODE onward
//   mem             : memory handshake (mem_req, mem_we, i_or_d, mem_ready)
//   ir_write        : load IR
//   pc_write        : unconditional PC load
//   pc_write_cond   : PC load when ALU zero == 0 (BNE)
//   pc_source       : 0 = ALU result, 1 = ALUOut
//   alu_src_a       : 0 = PC, 1 = register A
//   alu_src_b[1:0]  : 00 = B, 01 = 1, 10 = sign-extended imm, 11 = PC offset
//   alu_op[2:0]     : 000 AND, 001 OR, 011 ADD, 100 SUB, 101 SLT
//   reg_dst         : 1 = rd, 0 = rt
//   mem_to_reg      : 1 = MDR, 0 = ALUOut
//   reg_write       : register file write enable
//   state[3:0]      : current state (debug)
//   illegal         : sticky, undefined opcode decoded
//   bus_error       : sticky, memory request timed out
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [4:0]                  opcode,
  multicycle_control_if.master        mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_write_cond,
  output logic                        pc_source,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  alu_op,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        reg_write,
  output logic [3:0]                  state,
  output logic                        illegal,
  output logic                        bus_error
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  localparam logic [4:0] OP_AND = 5'h00;
  localparam logic [4:0] OP_OR  = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h02;
  localparam logic [4:0] OP_SUB = 5'h06;
  localparam logic [4:0] OP_SLT = 5'h07;
  localparam logic [4:0] OP_LW  = 5'h08;
  localparam logic [4:0] OP_SW  = 5'h0A;
  localparam logic [4:0] OP_BNE = 5'h0E;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [4:0]         op_reg, op_next;
  logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic               illegal_reg, illegal_next;
  logic               bus_error_reg, bus_error_next;

  // Raw (ungated) versions of the signals that must vanish during reset.
  logic               req_c, we_c, iod_c, ir_write_c, pc_write_c;
  logic               waiting;

  // ALU function for the R-type instruction latched in op_reg.
  function automatic logic [2:0] r_alu_op(input logic [4:0] op);
    logic [2:0] f;
    f = ALU_AND;
    case (op)
      OP_AND:  f = ALU_AND;
      OP_OR:   f = ALU_OR;
      OP_ADD:  f = ALU_ADD;
      OP_SUB:  f = ALU_SUB;
      OP_SLT:  f = ALU_SLT;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      op_reg        <= '0;
      wait_cnt_reg  <= '0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      wait_cnt_reg  <= wait_cnt_next;
      illegal_reg   <= illegal_next;
      bus_error_reg <= bus_error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    wait_cnt_next  = '0;
    illegal_next   = illegal_reg;
    bus_error_next = bus_error_reg;
    req_c          = 1'b0;
    we_c           = 1'b0;
    iod_c          = 1'b0;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_write_cond  = 1'b0;
    pc_source      = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    alu_op         = ALU_AND;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    waiting        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC + 1 is computed while the instruction is read.
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        req_c     = run;
        if (run && mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        op_next   = opcode;
        case (opcode)
          OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: state_next = S_EXEC_R;
          OP_LW, OP_SW:                          state_next = S_MEM_ADDR;
          OP_BNE:                                state_next = S_BRANCH;
          default: begin
            illegal_next = 1'b1;
            state_next   = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_op     = r_alu_op(op_reg);
        state_next = S_WB_R;
      end

      S_WB_R: begin
        // ALU function held so the result stays stable through write-back.
        alu_op     = r_alu_op(op_reg);
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = ALU_ADD;
        state_next = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iod_c = 1'b1;
        req_c = 1'b1;
        if (mem.mem_ready) state_next = S_WB_MEM;
      end

      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        iod_c = 1'b1;
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem.mem_ready) state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        alu_op        = ALU_SUB;
        pc_source     = 1'b1;
        pc_write_cond = 1'b1;
        state_next    = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase

    // Wait-state watchdog. A ready in the last allowed cycle completes the
    // request normally; otherwise the access is abandoned and the FSM goes
    // back to FETCH, which refetches the unchanged PC.
    waiting = req_c & ~mem.mem_ready;
    if (waiting && (wait_cnt_reg == WAIT_LAST)) begin
      bus_error_next = 1'b1;
      state_next     = S_FETCH;
      wait_cnt_next  = '0;
    end else if ((state_next != state_reg) || !req_c) begin
      wait_cnt_next = '0;
    end else if (waiting) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // Request and write strobes are gated by rst_n so an access in flight is
  // dropped the instant reset asserts, not at the next clock.
  assign mem.mem_req = req_c & rst_n;
  assign mem.mem_we  = we_c & rst_n;
  assign mem.i_or_d  = iod_c;
  assign ir_write    = ir_write_c & rst_n;
  assign pc_write    = pc_write_c & rst_n;
  assign state       = state_reg;
  assign illegal     = illegal_reg;
  assign bus_error   = bus_error_reg;

endmodule
